// File: rtl/cache_refill_controller.sv
// cache_refill_controller: fetch-side cache miss sequencer (COMPARE/FETCH/ALLOCATE) with optional hit/miss statistics.
//   Optional statistics counters are built only when CACHE_STATS_EN is defined; otherwise CNT_HIT/CNT_MISS read 0.
//   Ports:
//     CLK        in   system clock, rising edge
//     RESET      in   asynchronous active-low reset
//     REQ        in   fetch request, sampled only in IDLE
//     HIT        in   combinational tag match from the cache
//     Access_MM  out  main-memory read enable (FETCH)
//     Refill_WE  out  one-cycle line-fill write (ALLOCATE)
//     STALL      out  holds PC / fetch stage
//     DONE       out  one-cycle pulse, Data_Cache valid
//     CONT       out  state encoding
//     CNT_HIT    out  first-compare hit count (saturating)
//     CNT_MISS   out  miss count (saturating)
module cache_refill_controller #(
  parameter int MM_LATENCY = 2,
  parameter int CNT_W = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ,
  input  logic             HIT,
  output logic             Access_MM,
  output logic             Refill_WE,
  output logic             STALL,
  output logic             DONE,
  output logic [1:0]       CONT,
  output logic [CNT_W-1:0] CNT_HIT,
  output logic [CNT_W-1:0] CNT_MISS
);
  typedef enum logic [1:0] {IDLE = 2'b00, COMPARE = 2'b01, FETCH = 2'b10, ALLOCATE = 2'b11} state_t;
  state_t     state_q;
  logic [3:0] lat_q;
  logic       refill_q;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      refill_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (REQ) begin
          state_q  <= COMPARE;
          refill_q <= 1'b0;
        end
        COMPARE: if (HIT) state_q <= IDLE;
        else begin
          state_q <= FETCH;
          lat_q   <= 4'(MM_LATENCY - 1);
        end
        FETCH: begin
          lat_q   <= (lat_q == 4'd0) ? lat_q : lat_q - 4'd1;
          state_q <= (lat_q == 4'd0) ? ALLOCATE : FETCH;
        end
        default: begin
          refill_q <= 1'b1;
          state_q  <= COMPARE;
        end
      endcase
    end
  always_comb begin
    Access_MM = state_q == FETCH;
    Refill_WE = state_q == ALLOCATE;
    DONE      = state_q == COMPARE && HIT;
    STALL     = state_q == FETCH || state_q == ALLOCATE || (state_q == COMPARE && !HIT);
    CONT      = state_q;
  end
`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_q, miss_q;
  // Re-compares after a refill (refill_q set) are not counted as hits or new misses.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == COMPARE && !refill_q) begin
      if (HIT && !(&hit_q)) hit_q <= hit_q + 1'b1;
      if (!HIT && !(&miss_q)) miss_q <= miss_q + 1'b1;
    end
  assign CNT_HIT  = hit_q;
  assign CNT_MISS = miss_q;
`else
  assign CNT_HIT  = '0;
  assign CNT_MISS = '0;
`endif
endmodule

// File: tb/tb_cache_refill_controller.sv
// tb_cache_refill_controller: randomized scoreboard bench with a direct-mapped cache model driving HIT.
module tb_cache_refill_controller;
  localparam int L = 2;
  localparam int W = 4;
  logic CLK = 1'b0, RESET = 1'b0, REQ = 1'b0, HIT;
  logic Access_MM, Refill_WE, STALL, DONE;
  logic [1:0] CONT;
  logic [W-1:0] CNT_HIT, CNT_MISS;
  cache_refill_controller #(.MM_LATENCY(L), .CNT_W(W)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .HIT(HIT),
    .Access_MM(Access_MM), .Refill_WE(Refill_WE), .STALL(STALL), .DONE(DONE),
    .CONT(CONT), .CNT_HIT(CNT_HIT), .CNT_MISS(CNT_MISS)
  );
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge CLK) cyc++;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Cache model: 8-byte lines, 8 sets; refills can be forced to be dropped to provoke a second miss.
  logic [7:0]  vld = '0;
  logic [25:0] tags [8];
  logic [31:0] pc = '0;
  int nref = 0, ign_until = 0;
  always_comb HIT = vld[pc[5:3]] && tags[pc[5:3]] == pc[31:6];
  always @(posedge CLK)
    if (RESET && Refill_WE) begin
      if (nref >= ign_until) begin
        vld[pc[5:3]]  <= 1'b1;
        tags[pc[5:3]] <= pc[31:6];
      end
      nref++;
    end
  typedef struct {int start; int lat; int acc; int we; int eh; int em;} exp_t;
  exp_t q[$];
  bit mon_en = 0;
  int eh = 0, em = 0;
  initial begin : monitor
    int acc = 0, we = 0, st = 0;
    bit pend = 0;
    exp_t e, last;
    forever @(negedge CLK) if (mon_en) begin
      if (pend) begin
        chk("cnt_hit", int'(CNT_HIT), last.eh);
        chk("cnt_miss", int'(CNT_MISS), last.em);
        chk("cont_idle", int'(CONT), 0);
        pend = 0;
      end
      if (Access_MM) acc++;
      if (Refill_WE) we++;
      if (STALL) st++;
      if (DONE) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_latency", cyc - e.start + 1, e.lat);
          chk("access_cycles", acc, e.acc);
          chk("refill_pulses", we, e.we);
          chk("stall_cycles", st, e.lat - 1);
          last = e;
          pend = 1;
        end
        acc = 0; we = 0; st = 0;
      end
    end
  end
  initial begin
    int rc;
    bit fh, to;
    int nbad, lat, k, j;
    exp_t e;
    to = 0;
    #1;
    chk("rst_cont", int'(CONT), 0);
    chk("rst_access", int'(Access_MM), 0);
    chk("rst_refill", int'(Refill_WE), 0);
    chk("rst_stall", int'(STALL), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_cnt_hit", int'(CNT_HIT), 0);
    chk("rst_cnt_miss", int'(CNT_MISS), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    pc = 32'd0;
    REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
    @(posedge CLK);
    #2;
    chk("fetch_cont", int'(CONT), 2);
    chk("fetch_access", int'(Access_MM), 1);
    RESET = 1'b0;
    #1;
    chk("async_rst_cont", int'(CONT), 0);
    chk("async_rst_access", int'(Access_MM), 0);
    chk("async_rst_stall", int'(STALL), 0);
    @(negedge CLK);
    RESET = 1'b1;
    rc = 0;
    repeat (8) @(negedge CLK) if (Refill_WE) rc++;
    chk("no_refill_after_rst", rc, 0);
    chk("post_rst_cont", int'(CONT), 0);
    chk("post_rst_cnt_miss", int'(CNT_MISS), 0);
    mon_en = 1;
    for (int n = 0; n < 90 && !to; n++) begin
      pc = 32'($urandom_range(0, 31) * 4);
      fh = vld[pc[5:3]] && tags[pc[5:3]] == pc[31:6];
      nbad = fh ? 0 : ($urandom_range(0, 3) == 0 ? 1 : 0);
      lat = fh ? 1 : L + 3 + nbad * (L + 2);
      if (fh) eh = (eh < (1 << W) - 1) ? eh + 1 : eh;
      else em = (em < (1 << W) - 1) ? em + 1 : em;
      e.start = cyc + 1;
      e.lat = lat;
      e.acc = fh ? 0 : (1 + nbad) * L;
      e.we = fh ? 0 : 1 + nbad;
`ifdef CACHE_STATS_EN
      e.eh = eh;
      e.em = em;
`else
      e.eh = 0;
      e.em = 0;
`endif
      q.push_back(e);
      ign_until = nref + nbad;
      k = $urandom_range(1, lat);
      REQ = 1'b1;
      j = 0;
      forever begin
        @(negedge CLK);
        j++;
        if (j >= k) REQ = 1'b0;
        if (DONE) break;
        if (j > lat + 40) begin
          chk("done_timeout", 0, 1);
          to = 1;
          REQ = 1'b0;
          break;
        end
      end
      repeat (1 + $urandom_range(0, 2)) @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    chk("final_cont", int'(CONT), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
